// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler popping from two VC FIFOs and routing each
// word to one of two destination FIFOs by bit 4, with per-destination backpressure.
module vc_wrr_scheduler #(
    parameter int unsigned W0 = 3,
    parameter int unsigned W1 = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       VC0_empty,
    input  logic       VC1_empty,
    input  logic [5:0] data_VC0,
    input  logic [5:0] data_VC1,
    input  logic       full_D0,
    input  logic       full_D1,
    input  logic       almost_full_D0,
    input  logic       almost_full_D1,
    output logic       VC0_pop,
    output logic       VC1_pop,
    output logic       push_D0,
    output logic       push_D1,
    output logic [5:0] data_out,
    output logic [1:0] sched_state
);

    localparam int unsigned DW       = 6;
    localparam int unsigned CW       = 4;
    localparam int unsigned DEST_BIT = 4;

    localparam logic [CW-1:0] W0_L = CW'(W0);
    localparam logic [CW-1:0] W1_L = CW'(W1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    logic          cur_q;
    logic [CW-1:0] cnt_q;

    logic          cur_d;
    logic [CW-1:0] cnt_d;
    logic [1:0]    state_d;

    logic          pause_d0;
    logic          pause_d1;
    logic          elig0;
    logic          elig1;
    logic          elig_cur;
    logic          elig_oth;
    logic          grant;
    logic          gsel;
    logic [CW-1:0] n_cnt;
    logic [CW-1:0] w_sel;
    logic [DW-1:0] gword;

    // Eligibility: a VC may be served only if its head's destination is not paused
    always_comb begin
        pause_d0 = almost_full_D0 | full_D0;
        pause_d1 = almost_full_D1 | full_D1;
        elig0    = ~VC0_empty & ~(data_VC0[DEST_BIT] ? pause_d1 : pause_d0);
        elig1    = ~VC1_empty & ~(data_VC1[DEST_BIT] ? pause_d1 : pause_d0);
        elig_cur = cur_q ? elig1 : elig0;
        elig_oth = cur_q ? elig0 : elig1;
    end

    // Grant selection and weight bookkeeping
    always_comb begin
        grant   = 1'b0;
        gsel    = cur_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        n_cnt   = '0;
        w_sel   = W0_L;
        state_d = ST_STALL;

        if (!reset) begin
            if (elig_cur) begin
                grant = 1'b1;
                gsel  = cur_q;
            end else if (elig_oth) begin
                grant = 1'b1;
                gsel  = ~cur_q;
            end
        end

        w_sel = gsel ? W1_L : W0_L;
        if (grant) begin
            n_cnt = (gsel == cur_q) ? cnt_q + CW'(1) : CW'(1);
            if (n_cnt == w_sel) begin
                cur_d = ~gsel;
                cnt_d = '0;
            end else begin
                cur_d = gsel;
                cnt_d = n_cnt;
            end
        end

        if (grant) begin
            state_d = ST_ACTIVE;
        end else if (VC0_empty && VC1_empty) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_STALL;
        end
    end

    assign gword   = gsel ? data_VC1 : data_VC0;
    assign VC0_pop = grant & ~gsel;
    assign VC1_pop = grant & gsel;

    // Scheduler state and the one-cycle push stage
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q       <= 1'b0;
            cnt_q       <= '0;
            push_D0     <= 1'b0;
            push_D1     <= 1'b0;
            data_out    <= '0;
            sched_state <= ST_IDLE;
        end else begin
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            push_D0     <= grant & ~gword[DEST_BIT];
            push_D1     <= grant & gword[DEST_BIT];
            sched_state <= state_d;
            if (grant) begin
                data_out <= gword;
            end
        end
    end

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Directed bench for vc_wrr_scheduler: stimulus queues expected pushes and states,
// an independent monitor compares them against the registered outputs.
module tb_vc_wrr_scheduler;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACT  = 2'd1;
    localparam logic [1:0] STL  = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       VC0_empty = 1'b1;
    logic       VC1_empty = 1'b1;
    logic [5:0] data_VC0 = '0;
    logic [5:0] data_VC1 = '0;
    logic       full_D0 = 1'b0;
    logic       full_D1 = 1'b0;
    logic       almost_full_D0 = 1'b0;
    logic       almost_full_D1 = 1'b0;
    logic       VC0_pop;
    logic       VC1_pop;
    logic       push_D0;
    logic       push_D1;
    logic [5:0] data_out;
    logic [1:0] sched_state;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    logic [7:0] word_q[$];
    logic [1:0] state_q[$];

    vc_wrr_scheduler #(.W0(3), .W1(1)) dut (
        .clk(clk), .reset(reset),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .data_VC0(data_VC0), .data_VC1(data_VC1),
        .full_D0(full_D0), .full_D1(full_D1),
        .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
        .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
        .push_D0(push_D0), .push_D1(push_D1),
        .data_out(data_out), .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive after the edge, check pops mid-cycle, queue expectations.
    // fl = {full_D1, full_D0, almost_full_D1, almost_full_D0}
    task automatic step(input logic rst, input logic ne0, input logic ne1,
                        input logic [5:0] h0, input logic [5:0] h1, input logic [3:0] fl,
                        input logic xp0, input logic xp1, input logic [1:0] xst);
        @(posedge clk);
        #1;
        reset          = rst;
        VC0_empty      = ~ne0;
        VC1_empty      = ~ne1;
        data_VC0       = h0;
        data_VC1       = h1;
        {full_D1, full_D0, almost_full_D1, almost_full_D0} = fl;
        #4;
        chk("VC0_pop", int'(VC0_pop), int'(xp0));
        chk("VC1_pop", int'(VC1_pop), int'(xp1));
        if (xp0) word_q.push_back({h0[4], ~h0[4], h0});
        if (xp1) word_q.push_back({h1[4], ~h1[4], h1});
        state_q.push_back(xst);
    endtask

    task automatic chk_zero();
        chk("push_D0_after_reset", int'(push_D0), 0);
        chk("push_D1_after_reset", int'(push_D1), 0);
        chk("data_out_after_reset", int'(data_out), 0);
        chk("state_after_reset", int'(sched_state), int'(IDLE));
    endtask

    // Monitor: registered outputs sampled 3 time units after each edge
    always @(posedge clk) begin
        #3;
        if (push_D0 === 1'b1 || push_D1 === 1'b1) begin
            if (word_q.size() == 0) begin
                chk("unexpected_push", int'({push_D1, push_D0, data_out}), 0);
            end else begin
                chk("push_word", int'({push_D1, push_D0, data_out}), int'(word_q.pop_front()));
            end
        end
        if (state_q.size() != 0) begin
            chk("sched_state", int'(sched_state), int'(state_q.pop_front()));
        end
    end

    initial begin
        // Reset with both VCs non-empty: no pops
        step(1, 1, 1, 6'h01, 6'h02, 4'b0000, 0, 0, IDLE);
        step(1, 1, 1, 6'h01, 6'h02, 4'b0000, 0, 0, IDLE);
        chk_zero();

        // W0=3, W1=1 pattern, all to D0
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 6'(i + 1), 6'(6'h20 + i), 4'b0000,
                 (i % 4) != 3, (i % 4) == 3, ACT);
        end

        // D0 almost full: VC1 (to D1) keeps flowing
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 6'h05, 6'h12, 4'b0001, 0, 1, ACT);
        end

        // Only VC1 non-empty; cur returns to VC0 each time
        step(0, 0, 1, 6'h00, 6'h13, 4'b0000, 0, 1, ACT);
        step(0, 0, 1, 6'h00, 6'h13, 4'b0000, 0, 1, ACT);
        step(0, 1, 1, 6'h07, 6'h13, 4'b0000, 1, 0, ACT);
        step(0, 1, 1, 6'h08, 6'h13, 4'b0000, 1, 0, ACT);

        // Both heads to D1 while full_D1: stall, then resume with cnt preserved
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 6'h11, 6'h31, 4'b1000, 0, 0, STL);
        end
        step(0, 1, 1, 6'h11, 6'h31, 4'b0000, 1, 0, ACT);
        // Idle cycle, then VC1 preferred
        step(0, 0, 0, 6'h00, 6'h00, 4'b0000, 0, 0, IDLE);
        step(0, 1, 1, 6'h14, 6'h32, 4'b0000, 0, 1, ACT);

        // Pop 6'h1A from VC0, then reset: the word still pushes once
        step(0, 1, 0, 6'h1A, 6'h00, 4'b0000, 1, 0, ACT);
        step(1, 1, 1, 6'h01, 6'h02, 4'b0000, 0, 0, IDLE);
        step(1, 1, 1, 6'h01, 6'h02, 4'b0000, 0, 0, IDLE);
        chk_zero();

        // After reset cur is VC0 again
        step(0, 1, 1, 6'h03, 6'h24, 4'b0000, 1, 0, ACT);
        step(0, 0, 0, 6'h00, 6'h00, 4'b0000, 0, 0, IDLE);
        step(0, 0, 0, 6'h00, 6'h00, 4'b0000, 0, 0, IDLE);

        @(posedge clk);
        #5;
        chk("words_left", word_q.size(), 0);
        chk("states_left", state_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
